pad_game_engine: RTL
====================

PAD_GAME_ENGINE -- requirements
Module: pad_game_engine

Interface
REQ-001 Parameter NUM_PADS, default 3; number of target pads, legal range 2..8.
REQ-002 Parameter SENSE_BITS, default 5; sensor bits per pad, MSB = centre zone, remaining bits = rim zones.
REQ-003 Parameter TIMEOUT, default 20000000; ACTIVE-window length in clocks, must be >= 3.
REQ-004 Parameter ROUNDS, default 20; rounds per game.
REQ-005 Parameters CENTER_PTS / RIM_PTS / WRONG_PTS, defaults 4 / 2 / 1; score award, award and penalty.
REQ-006 Parameter SCORE_W, default 10; score width.
REQ-007 iVGA_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-008 iRST  in  1  synchronous, active-high reset.
REQ-009 iStart  in  1  single-cycle pulse; begins a game from IDLE or GAMEOVER.
REQ-010 iAbort  in  1  returns the engine to IDLE from any state.
REQ-011 iSensor  in  NUM_PADS*SENSE_BITS  active-low pad sensors; pad p occupies bits [p*SENSE_BITS +: SENSE_BITS].
REQ-012 iSeed  in  16  LFSR seed, loaded on iStart; the value 0 is replaced by 16'hACE1.
REQ-013 oPadSel  out  NUM_PADS  active-low one-hot target-pad drive; all ones when no target is lit.
REQ-014 oPhase  out  2  animation phase: 0 = none, 1..3 = thirds of the window.
REQ-015 oScore  out  SCORE_W  current score.
REQ-016 oRound  out  8  count of completed rounds.
REQ-017 oHit / oMiss  out  1 each  single-cycle pulses at round end.
REQ-018 oGameOver  out  1  high while in GAMEOVER.

Function
REQ-019 The sensor input shall pass through a 2-flop synchroniser; all decisions use the synchronised value.
REQ-020 The state machine shall have states IDLE, ARM, SELECT, ACTIVE, GAMEOVER.
REQ-021 IDLE/GAMEOVER + iStart: score := 0, round := 0, LFSR := seed, then go to ARM.
REQ-022 ARM: wait until every synchronised sensor bit is 1, then go to SELECT on the following cycle.
REQ-023 SELECT: one cycle; LFSR steps once (x^16+x^14+x^13+x^11); target := LFSR[7:0] mod NUM_PADS; oPadSel[target] := 0; window counter := 0; go to ACTIVE.
REQ-024 ACTIVE: counter increments each cycle; oPhase = 1 while count < TIMEOUT/3, 2 while count < 2*TIMEOUT/3, otherwise 3 (integer division).
REQ-025 Target hit means any bit of the target group is 0; centre bit 0 awards CENTER_PTS, otherwise RIM_PTS; awards are never summed; oHit pulses.
REQ-026 Wrong hit means any non-target group has a 0 bit while the target group is all ones; score is reduced by WRONG_PTS, saturating at 0; oMiss pulses.
REQ-027 When count reaches TIMEOUT-1 with no hit: oMiss pulses and the score is unchanged.
REQ-028 Simultaneous events resolve by priority: target hit > wrong hit > timeout.
REQ-029 Score addition shall saturate at 2^SCORE_W-1.
REQ-030 On any round end: oPadSel := all ones, oPhase := 0, round += 1; go to GAMEOVER if round == ROUNDS, else to ARM.
REQ-031 iStart shall be ignored in ARM, SELECT and ACTIVE.
REQ-032 iAbort shall have priority over iStart and all events; the next cycle is IDLE with outputs idle and the score held.

Reset
REQ-033 While iRST is high on a clock edge: state = IDLE, oPadSel = all ones, oPhase = 0, oScore = 0, oRound = 0, oHit = oMiss = oGameOver = 0, synchroniser = all ones, LFSR = 16'hACE1.
REQ-034 Reset asserted mid-ACTIVE shall abandon the round with no score change and no pulse.

Structure
REQ-035 A shared package pad_game_pkg shall hold the state enum, the default LFSR seed and the default parameter values.
REQ-036 The LFSR shall be a separate sub-module named lfsr16 with load, step, seed and value ports.
REQ-037 The engine body shall be one registered FSM; all outputs are registered.

Verification (NUM_PADS=3, TIMEOUT=12, ROUNDS=3)
REQ-038 Reset, then idle sensors -> oPadSel=3'b111, oScore=0, oPhase=0, state IDLE.
REQ-039 iStart; drive the target pad's centre bit low 5 cycles into ACTIVE -> oHit pulse, oScore=4, oPhase was 2 at the hit cycle, engine in ARM until release.
REQ-040 No touch -> oPhase sequence 1,1,1,1,2,2,2,2,3,3,3,3, then oMiss at count 11 with oScore unchanged.
REQ-041 Wrong pad hit at score 0 -> oScore stays 0 (saturation), oMiss pulse; target and wrong pad hit in the same cycle -> oHit only.
REQ-042 Three rounds completed -> oRound=3, oGameOver=1; iStart -> oScore=0, oRound=0; iAbort mid-ACTIVE -> IDLE next cycle, oPadSel=3'b111.

Source files
------------

// File: rtl/pad_game_pkg.sv
// Shared types, defaults and LFSR helpers for the pad game engine.
package pad_game_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StSelect,
    StActive,
    StGameOver
  } state_e;

  localparam logic [15:0] LfsrDefaultSeed = 16'hACE1;

  localparam int unsigned DefNumPads   = 3;
  localparam int unsigned DefSenseBits = 5;
  localparam int unsigned DefTimeout   = 20000000;
  localparam int unsigned DefRounds    = 20;
  localparam int unsigned DefCenterPts = 4;
  localparam int unsigned DefRimPts    = 2;
  localparam int unsigned DefWrongPts  = 1;
  localparam int unsigned DefScoreW    = 10;

  // Fibonacci step for x^16+x^14+x^13+x^11, shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // An all-zero seed would lock the LFSR, so it is swapped for the default.
  function automatic logic [15:0] lfsr_seed(input logic [15:0] s);
    return (s == 16'h0000) ? LfsrDefaultSeed : s;
  endfunction

endpackage

// File: rtl/pad_game_engine_if.sv
// Control, sensor and score signals between the pad game engine and its host.
interface pad_game_engine_if
  import pad_game_pkg::*;
#(
  parameter int unsigned NUM_PADS   = DefNumPads,
  parameter int unsigned SENSE_BITS = DefSenseBits,
  parameter int unsigned SCORE_W    = DefScoreW
);
  logic                           iStart;
  logic                           iAbort;
  logic [NUM_PADS*SENSE_BITS-1:0] iSensor;
  logic [15:0]                    iSeed;
  logic [NUM_PADS-1:0]            oPadSel;
  logic [1:0]                     oPhase;
  logic [SCORE_W-1:0]             oScore;
  logic [7:0]                     oRound;
  logic                           oHit;
  logic                           oMiss;
  logic                           oGameOver;

  modport master (
    output iStart, iAbort, iSensor, iSeed,
    input  oPadSel, oPhase, oScore, oRound, oHit, oMiss, oGameOver
  );

  modport slave (
    input  iStart, iAbort, iSensor, iSeed,
    output oPadSel, oPhase, oScore, oRound, oHit, oMiss, oGameOver
  );
endinterface

// File: rtl/lfsr16.sv
// 16-bit LFSR used to pick the target pad; loads a seed or steps once per request.
module lfsr16
  import pad_game_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [15:0] seed_i,
  output logic [15:0] value_o
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d = lfsr_seed(seed_i);
    end else if (step_i) begin
      value_d = lfsr_next(value_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= LfsrDefaultSeed;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/pad_game_engine.sv
// Reaction game: light a random pad, score centre/rim hits, penalise wrong pads,
// time out after a fixed window. All outputs are registered.
module pad_game_engine
  import pad_game_pkg::*;
#(
  parameter int unsigned NUM_PADS   = DefNumPads,
  parameter int unsigned SENSE_BITS = DefSenseBits,
  parameter int unsigned TIMEOUT    = DefTimeout,
  parameter int unsigned ROUNDS     = DefRounds,
  parameter int unsigned CENTER_PTS = DefCenterPts,
  parameter int unsigned RIM_PTS    = DefRimPts,
  parameter int unsigned WRONG_PTS  = DefWrongPts,
  parameter int unsigned SCORE_W    = DefScoreW
) (
  input logic              iVGA_CLK,
  input logic              iRST,
  pad_game_engine_if.slave bus
);

  localparam int unsigned SensW = NUM_PADS * SENSE_BITS;
  localparam int unsigned TgtW  = $clog2(NUM_PADS);
  localparam int unsigned CntW  = $clog2(TIMEOUT);
  localparam int unsigned Sw1   = SCORE_W + 1;

  localparam logic [CntW-1:0] Third1  = CntW'(TIMEOUT / 3);
  localparam logic [CntW-1:0] Third2  = CntW'((2 * TIMEOUT) / 3);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT - 1);
  localparam logic [Sw1-1:0]  ScoreMax = {1'b0, {SCORE_W{1'b1}}};
  localparam logic [7:0]      RoundsL  = 8'(ROUNDS);

  function automatic logic [1:0] phase_of(input logic [CntW-1:0] c);
    if (c < Third1) return 2'd1;
    if (c < Third2) return 2'd2;
    return 2'd3;
  endfunction

  state_e              state_q, state_d;
  logic [SensW-1:0]    sync1_q, sync2_q;
  logic [NUM_PADS-1:0] pad_sel_q, pad_sel_d;
  logic [1:0]          phase_q, phase_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [7:0]          round_q, round_d;
  logic                hit_q, hit_d, miss_q, miss_d, over_q, over_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TgtW-1:0]     tgt_q, tgt_d;

  logic                lfsr_load, lfsr_step, round_end;
  logic [15:0]         lfsr_val, lfsr_nxt;
  logic [TgtW-1:0]     tgt_new;
  logic [NUM_PADS-1:0] sel_new;
  logic                tgt_zero, tgt_ctr, other_zero;
  logic [Sw1-1:0]      pts, sum;
  logic [SCORE_W-1:0]  score_add, score_sub;
  logic                unused_lfsr;

  lfsr16 u_lfsr (
    .clk_i   (iVGA_CLK),
    .rst_i   (iRST),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .seed_i  (bus.iSeed),
    .value_o (lfsr_val)
  );

  // Target is taken from the value the LFSR steps to while in SELECT.
  assign lfsr_nxt    = lfsr_next(lfsr_val);
  assign unused_lfsr = ^lfsr_nxt[15:8];
  assign tgt_new     = TgtW'(32'(lfsr_nxt[7:0]) % NUM_PADS);

  always_comb begin
    tgt_zero   = 1'b0;
    tgt_ctr    = 1'b0;
    other_zero = 1'b0;
    sel_new    = '1;
    for (int p = 0; p < NUM_PADS; p++) begin
      sel_new[p] = (TgtW'(p) != tgt_new);
      if (TgtW'(p) == tgt_q) begin
        tgt_zero = ~&sync2_q[p*SENSE_BITS +: SENSE_BITS];
        tgt_ctr  = ~sync2_q[p*SENSE_BITS + SENSE_BITS - 1];
      end else begin
        other_zero = other_zero | ~&sync2_q[p*SENSE_BITS +: SENSE_BITS];
      end
    end
    pts       = tgt_ctr ? Sw1'(CENTER_PTS) : Sw1'(RIM_PTS);
    sum       = {1'b0, score_q} + pts;
    score_add = (sum > ScoreMax) ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    score_sub = ({1'b0, score_q} < Sw1'(WRONG_PTS)) ? '0 : score_q - SCORE_W'(WRONG_PTS);
  end

  always_comb begin
    state_d   = state_q;
    pad_sel_d = pad_sel_q;
    phase_d   = phase_q;
    score_d   = score_q;
    round_d   = round_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    over_d    = over_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    round_end = 1'b0;

    if (bus.iAbort) begin
      state_d   = StIdle;
      pad_sel_d = '1;
      phase_d   = 2'd0;
      over_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StGameOver: begin
          if (bus.iStart) begin
            score_d   = '0;
            round_d   = '0;
            over_d    = 1'b0;
            lfsr_load = 1'b1;
            state_d   = StArm;
          end
        end
        StArm: begin
          if (&sync2_q) state_d = StSelect;
        end
        StSelect: begin
          lfsr_step = 1'b1;
          tgt_d     = tgt_new;
          pad_sel_d = sel_new;
          cnt_d     = '0;
          phase_d   = phase_of('0);
          state_d   = StActive;
        end
        StActive: begin
          cnt_d   = cnt_q + 1'b1;
          phase_d = phase_of(cnt_q + 1'b1);
          if (tgt_zero) begin
            score_d   = score_add;
            hit_d     = 1'b1;
            round_end = 1'b1;
          end else if (other_zero) begin
            score_d   = score_sub;
            miss_d    = 1'b1;
            round_end = 1'b1;
          end else if (cnt_q == LastCnt) begin
            miss_d    = 1'b1;
            round_end = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (round_end) begin
      pad_sel_d = '1;
      phase_d   = 2'd0;
      round_d   = round_q + 8'd1;
      if (round_q + 8'd1 == RoundsL) begin
        state_d = StGameOver;
        over_d  = 1'b1;
      end else begin
        state_d = StArm;
      end
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      state_q   <= StIdle;
      sync1_q   <= '1;
      sync2_q   <= '1;
      pad_sel_q <= '1;
      phase_q   <= 2'd0;
      score_q   <= '0;
      round_q   <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      over_q    <= 1'b0;
      cnt_q     <= '0;
      tgt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= bus.iSensor;
      sync2_q   <= sync1_q;
      pad_sel_q <= pad_sel_d;
      phase_q   <= phase_d;
      score_q   <= score_d;
      round_q   <= round_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      over_q    <= over_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
    end
  end

  assign bus.oPadSel   = pad_sel_q;
  assign bus.oPhase    = phase_q;
  assign bus.oScore    = score_q;
  assign bus.oRound    = round_q;
  assign bus.oHit      = hit_q;
  assign bus.oMiss     = miss_q;
  assign bus.oGameOver = over_q;

endmodule
